seq_mul4b: RTL and testbench



---
 rtl/mul_pkg.sv | 12 +
 rtl/add_w_co.sv | 18 +
 rtl/seq_mul4b.sv | 72 +++++++
 tb/tb_seq_mul4b.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, default width and counter-width helper
// for the sequential shift-and-add multiplier.
package mul_pkg;
    localparam int MUL_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/add_w_co.sv
// add_w_co: W-bit ripple-carry adder built from full-adder cells.
module add_w_co #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[W];
endmodule

// File: rtl/seq_mul4b.sv
// seq_mul4b: unsigned shift-and-add multiplier, one add/shift per clock,
// start/done handshake with back-to-back acceptance from DONE.
module seq_mul4b
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done
);
    localparam int CW = clog2(W);
    state_t           state_q, state_d;
    logic [W-1:0]     m_q, m_d, a_q, a_d, q_q, q_d, sum;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   p_q, p_d, shifted;
    logic             co;
    add_w_co #(.W(W)) u_add (
        .a(a_q), .b(m_q), .cin(1'b0), .sum(sum), .cout(co)
    );
    // The carry lands in the top bit of the shifted pair, so it never needs its own state.
    assign shifted = q_q[0] ? {co, sum, q_q[W-1:1]} : {1'b0, a_q, q_q[W-1:1]};
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        if (state_q == CALC) begin
            {a_d, q_d} = shifted;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                p_d     = shifted;
                state_d = DONE;
            end
        end else if (start && (state_q == IDLE || state_q == DONE)) begin
            m_d     = x;
            q_d     = y;
            a_d     = '0;
            cnt_d   = '0;
            state_d = CALC;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end
    assign p    = p_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_seq_mul4b.sv
// tb_seq_mul4b: directed self-checking bench for seq_mul4b (W=4).
module tb_seq_mul4b;
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       start = 1'b0;
    logic [3:0] x = '0, y = '0;
    logic [7:0] p;
    logic       busy, done;
    int         n_vec = 0;
    int         n_err = 0;

    seq_mul4b #(.W(4)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .x(x), .y(y),
        .p(p), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        step();
        step();
        n_vec++; if (p !== 8'd0) begin n_err++; $display("FAIL reset_p: got %0d want 0", p); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_basic();
        start = 1'b1; x = 4'd13; y = 4'd11;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL basic_busy[%0d]: busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            step();
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        n_vec++; if (p !== 8'd143) begin n_err++; $display("FAIL basic_p: got %0d want 143", p); end
        step();
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: done=%b busy=%b want 0 0", done, busy); end
        n_vec++; if (p !== 8'd143) begin n_err++; $display("FAIL basic_hold: got %0d want 143", p); end
    endtask

    task automatic test_carry();
        int cyc;
        start = 1'b1; x = 4'd15; y = 4'd15;
        step();
        start = 1'b0;
        wait_done(cyc);
        n_vec++; if (done !== 1'b1 || p !== 8'hE1) begin n_err++; $display("FAIL carry_p: done=%b p=%h want 1 e1", done, p); end
        step();
        start = 1'b1; x = 4'd0; y = 4'd9;
        step();
        start = 1'b0;
        step();
        step();
        n_vec++; if (p !== 8'hE1) begin n_err++; $display("FAIL carry_hold: got %h want e1", p); end
        wait_done(cyc);
        n_vec++; if (done !== 1'b1 || p !== 8'd0) begin n_err++; $display("FAIL zero_p: done=%b p=%0d want 1 0", done, p); end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        start = 1'b1; x = 4'd2; y = 4'd3;
        step();
        start = 1'b0;
        wait_done(cyc);
        n_vec++; if (done !== 1'b1 || p !== 8'd6) begin n_err++; $display("FAIL b2b_first: done=%b p=%0d want 1 6", done, p); end
        start = 1'b1; x = 4'd1; y = 4'd9;
        step();
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_nobubble: busy=%b want 1", busy); end
        wait_done(cyc);
        cyc++;
        n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL b2b_spacing: got %0d cycles want 5", cyc); end
        n_vec++; if (p !== 8'd9) begin n_err++; $display("FAIL b2b_p: got %0d want 9", p); end
        step();
    endtask

    task automatic test_ignore();
        int cyc;
        start = 1'b1; x = 4'd3; y = 4'd5;
        step();
        start = 1'b0;
        step();
        start = 1'b1; x = 4'd15; y = 4'd15;
        step();
        start = 1'b0;
        wait_done(cyc);
        n_vec++; if (done !== 1'b1 || p !== 8'd15) begin n_err++; $display("FAIL ignore_p: done=%b p=%0d want 1 15", done, p); end
        step();
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL ignore_idle: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_async_reset();
        bit seen;
        start = 1'b1; x = 4'd7; y = 4'd7;
        step();
        start = 1'b0;
        step();
        #2 rst_b = 1'b0;
        #1;
        n_vec++; if (p !== 8'd0) begin n_err++; $display("FAIL areset_p: got %0d want 0", p); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL areset_flags: busy=%b done=%b want 0 0", busy, done); end
        step();
        #2 rst_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL areset_quiet: activity seen after release"); end
    endtask

    task automatic test_exhaustive();
        int cyc;
        logic [7:0] exp_p;
        start = 1'b1; x = 4'd0; y = 4'd0;
        exp_p = 8'd0;
        step();
        for (int k = 1; k <= 256; k++) begin
            start = 1'b0;
            wait_done(cyc);
            n_vec++;
            if (done !== 1'b1 || p !== exp_p) begin
                n_err++; $display("FAIL exh_p[%0d]: done=%b p=%0d want %0d", k - 1, done, p, exp_p);
            end
            if (k < 256) begin
                x = 4'(k >> 4); y = 4'(k);
                exp_p = 8'(k >> 4) * 8'(k & 15);
                start = 1'b1;
            end
            step();
            n_vec++;
            if (done !== 1'b0) begin n_err++; $display("FAIL exh_width[%0d]: done=%b want 0", k - 1, done); end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_ignore();
        test_async_reset();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
